// File: rtl/audio_pkg.sv
// Shared definitions for the audio record and playback paths.
//   - rec_state_e : transport FSM states, encoded as shown on the LCD
//   - LrckLeft/LrckRight : LRCK level for each channel half of an I2S frame
//   - DataW : sample width, MSB first on the serial line
package audio_pkg;

  localparam int unsigned DataW = 16;

  localparam logic LrckLeft  = 1'b0;
  localparam logic LrckRight = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArm     = 2'd1,
    StCapture = 2'd2,
    StPause   = 2'd3
  } rec_state_e;

endpackage

// File: rtl/i2s_rx_shift.sv
// I2S left-channel receiver.
// Detects the LRCK right->left edge, skips the one-bit I2S delay slot, then
// shifts in DATA_W bits MSB first. The right half of each frame is ignored.
// Ports:
//   i_clk     codec bit clock, rising edge
//   i_rst     asynchronous active-low reset
//   i_en      shifter may start/advance (FSM in ARM or CAPTURE)
//   i_clear   drop any partial word and idle the shifter (wins over i_en)
//   i_lrck    AUD_ADCLRCK
//   i_dat     AUD_ADCDAT
//   o_fall    LRCK falling edge seen at this clock edge
//   o_valid   1-cycle strobe: o_sample holds a complete left word
//   o_sample  received word, stable while o_valid is high
module i2s_rx_shift
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W = DataW
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_clear,
  input  logic              i_lrck,
  input  logic              i_dat,
  output logic              o_fall,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_sample
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  logic              lrck_q;
  logic              active_q, active_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              valid_q, valid_d;

  assign o_fall   = (lrck_q == LrckRight) && (i_lrck == LrckLeft);
  assign o_valid  = valid_q;
  assign o_sample = shreg_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    valid_d  = 1'b0;
    if (i_clear) begin
      active_d = 1'b0;
      cnt_d    = '0;
    end else if (i_en) begin
      if (o_fall) begin
        // This edge carries the previous word's LSB; data starts next edge.
        // A fall mid-word also lands here and restarts the count.
        active_d = 1'b1;
        cnt_d    = '0;
      end else if (active_q) begin
        shreg_d = {shreg_q[DATA_W-2:0], i_dat};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          active_d = 1'b0;
          cnt_d    = '0;
          valid_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      lrck_q   <= 1'b0;
      active_q <= 1'b0;
      cnt_q    <= '0;
      shreg_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      lrck_q   <= i_lrck;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: rtl/audio_recorder.sv
// Record path: captures left-channel ADC samples and writes them to SRAM.
// Ports:
//   i_clk, i_rst                  bit clock / async active-low reset
//   i_record                      1 = record mode; 0 forces IDLE
//   i_recordorpause, i_stop       1-cycle key pulses
//   i_aud_ADClrck, i_aud_ADCdat   codec ADC I2S stream
//   o_state                       IDLE/ARM/CAPTURE/PAUSE for the LCD
//   o_sram_wr_req/addr/wdata      write request, held until i_sram_wr_ack
//   i_sram_wr_ack                 1-cycle accept pulse
//   o_rec_len                     acknowledged samples in this take
//   o_rec_sec                     recorded seconds, saturating at 255
//   o_full                        1-cycle pulse when ADDR_MAX is written
//   o_overrun                     sticky, a sample was dropped this take
module audio_recorder
  import audio_pkg::*;
#(
  parameter int unsigned       DATA_W    = DataW,
  parameter int unsigned       ADDR_W    = 20,
  parameter logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}},
  parameter int unsigned       SAMPLE_HZ = 32000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_record,
  input  logic              i_recordorpause,
  input  logic              i_stop,
  input  logic              i_aud_ADClrck,
  input  logic              i_aud_ADCdat,
  output logic [1:0]        o_state,
  output logic              o_sram_wr_req,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_wdata,
  input  logic              i_sram_wr_ack,
  output logic [ADDR_W-1:0] o_rec_len,
  output logic [7:0]        o_rec_sec,
  output logic              o_full,
  output logic              o_overrun
);

  localparam int unsigned SubW = (SAMPLE_HZ > 1) ? $clog2(SAMPLE_HZ) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(SAMPLE_HZ - 1);

  rec_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        sec_q, sec_d;
  logic [SubW-1:0]   sub_q, sub_d;
  logic              full_q, full_d;
  logic              ovr_q, ovr_d;

  logic              sh_en, sh_clear, sh_fall, sh_valid;
  logic [DATA_W-1:0] sh_sample;
  logic              ack_ok, full_hit, start_take, sample_ok;

  i2s_rx_shift #(
    .DATA_W (DATA_W)
  ) u_shift (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (sh_en),
    .i_clear  (sh_clear),
    .i_lrck   (i_aud_ADClrck),
    .i_dat    (i_aud_ADCdat),
    .o_fall   (sh_fall),
    .o_valid  (sh_valid),
    .o_sample (sh_sample)
  );

  assign ack_ok   = req_q & i_sram_wr_ack;
  assign full_hit = ack_ok & (addr_q == ADDR_MAX);

  always_comb begin
    state_d = state_q;
    if (!i_record) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:    if (i_recordorpause) state_d = StArm;
        StArm: begin
          if (i_stop)       state_d = StIdle;
          else if (sh_fall) state_d = StCapture;
        end
        StCapture: begin
          if (i_stop)               state_d = StIdle;
          else if (i_recordorpause) state_d = StPause;
        end
        StPause: begin
          if (i_stop)               state_d = StIdle;
          else if (i_recordorpause) state_d = StArm;
        end
        default:   state_d = StIdle;
      endcase
      // Memory exhausted: ends the take whatever the transport state.
      if (full_hit) state_d = StIdle;
    end
  end

  assign start_take = (state_q == StIdle) && (state_d == StArm);
  assign sh_en      = (state_q == StArm) || (state_q == StCapture);
  // Partial words are dropped whenever we are not going to keep capturing.
  assign sh_clear   = !((state_d == StArm) || (state_d == StCapture));
  // A word completing as the take is stopped is discarded with it.
  assign sample_ok  = sh_valid && (state_q == StCapture) && (state_d != StIdle);

  always_comb begin
    req_d   = req_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    len_d   = len_q;
    sec_d   = sec_q;
    sub_d   = sub_q;
    ovr_d   = ovr_q;
    full_d  = full_hit;

    if (ack_ok) begin
      req_d = 1'b0;
      len_d = len_q + 1'b1;
      if (sub_q == SubLast) begin
        sub_d = '0;
        if (sec_q != 8'hFF) sec_d = sec_q + 8'd1;
      end else begin
        sub_d = sub_q + 1'b1;
      end
    end

    if (sample_ok) begin
      if (req_q) begin
        ovr_d = 1'b1;
      end else begin
        req_d   = 1'b1;
        addr_d  = len_q;
        wdata_d = sh_sample;
      end
    end

    // Leaving the take withdraws any unacknowledged write.
    if (state_d == StIdle) req_d = 1'b0;

    if (start_take) begin
      req_d  = 1'b0;
      addr_d = '0;
      len_d  = '0;
      sec_d  = '0;
      sub_d  = '0;
      ovr_d  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      len_q   <= '0;
      sec_q   <= '0;
      sub_q   <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      len_q   <= len_d;
      sec_q   <= sec_d;
      sub_q   <= sub_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_state       = state_q;
  assign o_sram_wr_req = req_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_wdata  = wdata_q;
  assign o_rec_len     = len_q;
  assign o_rec_sec     = sec_q;
  assign o_full        = full_q;
  assign o_overrun     = ovr_q;

endmodule

// File: tb/tb_audio_recorder.sv
module tb_audio_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic lrck, dat;

  // Default-parameter instance
  logic        record, rop, stop, ack;
  logic [1:0]  state;
  logic        req, full, ovr;
  logic [19:0] addr, rec_len;
  logic [15:0] wdata;
  logic [7:0]  sec;

  // Small instance: ADDR_MAX=7, SAMPLE_HZ=4
  logic        record_s, rop_s, stop_s, ack_s;
  logic [1:0]  state_s;
  logic        req_s, full_s, ovr_s;
  logic [19:0] addr_s, rec_len_s;
  logic [15:0] wdata_s;
  logic [7:0]  sec_s;

  audio_recorder dut (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_record        (record),
    .i_recordorpause (rop),
    .i_stop          (stop),
    .i_aud_ADClrck   (lrck),
    .i_aud_ADCdat    (dat),
    .o_state         (state),
    .o_sram_wr_req   (req),
    .o_sram_addr     (addr),
    .o_sram_wdata    (wdata),
    .i_sram_wr_ack   (ack),
    .o_rec_len       (rec_len),
    .o_rec_sec       (sec),
    .o_full          (full),
    .o_overrun       (ovr)
  );

  audio_recorder #(
    .ADDR_MAX  (20'd7),
    .SAMPLE_HZ (4)
  ) dut_s (
    .i_clk           (clk),
    .i_rst           (rst_n),
    .i_record        (record_s),
    .i_recordorpause (rop_s),
    .i_stop          (stop_s),
    .i_aud_ADClrck   (lrck),
    .i_aud_ADCdat    (dat),
    .o_state         (state_s),
    .o_sram_wr_req   (req_s),
    .o_sram_addr     (addr_s),
    .o_sram_wdata    (wdata_s),
    .i_sram_wr_ack   (ack_s),
    .o_rec_len       (rec_len_s),
    .o_rec_sec       (sec_s),
    .o_full          (full_s),
    .o_overrun       (ovr_s)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [19:0] addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  logic auto_ack   = 1'b0;
  logic auto_ack_s = 1'b0;
  int   wr_cnt_s   = 0;
  int   full_cnt   = 0;
  int   full_cnt_s = 0;

  // SRAM model: acknowledges a visible request one cycle later when enabled
  initial begin
    ack   = 1'b0;
    ack_s = 1'b0;
    forever begin
      @(negedge clk);
      ack   = auto_ack & req;
      ack_s = auto_ack_s & req_s;
    end
  end

  // Monitor: every new write request is compared with the scoreboard head
  initial begin
    logic prev, prev_s;
    wr_t  e;
    prev   = 1'b0;
    prev_s = 1'b0;
    forever begin
      @(negedge clk);
      if (req && !prev) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: addr %0h data %0h, none expected", addr, wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", addr, e.addr);
          chk("wr_data", wdata, e.data);
        end
      end
      if (req_s && !prev_s) wr_cnt_s++;
      if (full) full_cnt++;
      if (full_s) full_cnt_s++;
      prev   = req;
      prev_s = req_s;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic slot(input logic l, input logic d);
    @(negedge clk);
    lrck = l;
    dat  = d;
  endtask

  // One I2S frame: slot 0 is the delay slot (driven 1 as junk), then left MSB first
  task automatic frame(input logic [15:0] left, input logic [15:0] right, input int nslots = 32);
    logic l, d;
    for (int i = 0; i < nslots; i++) begin
      l = (i < 16) ? 1'b0 : 1'b1;
      if (i == 0)       d = 1'b1;
      else if (i <= 16) d = left[16-i];
      else              d = right[32-i];
      slot(l, d);
    end
  endtask

  task automatic pulse(input logic p_rop, input logic p_stop, input logic p_rop_s);
    @(negedge clk);
    rop   = p_rop;
    stop  = p_stop;
    rop_s = p_rop_s;
    @(negedge clk);
    rop   = 1'b0;
    stop  = 1'b0;
    rop_s = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    record   = 1'b0;
    rop      = 1'b0;
    stop     = 1'b0;
    record_s = 1'b0;
    rop_s    = 1'b0;
    stop_s   = 1'b0;
    lrck     = 1'b1;
    dat      = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);

    chk("reset_state", state, 2'd0);
    chk("reset_req", req, 1'b0);
    chk("reset_len", rec_len, 20'd0);
    chk("reset_sec", sec, 8'd0);
    chk("reset_ovr", ovr, 1'b0);
    chk("reset_addr", addr, 20'd0);

    // First take: A5C3 at address 0
    record = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    chk("arm_state", state, 2'd1);
    auto_ack = 1'b1;
    exp_q.push_back('{addr: 20'd0, data: 16'hA5C3});
    frame(16'hA5C3, 16'hFFFF);
    chk("t2_len", rec_len, 20'd1);
    chk("t2_state", state, 2'd2);
    chk("t2_ovr", ovr, 1'b0);
    chk("t2_drained", exp_q.size(), 0);

    // Ack withheld across two more frames: both dropped, first held
    auto_ack = 1'b0;
    exp_q.push_back('{addr: 20'd1, data: 16'h1234});
    frame(16'h1234, 16'h0000);
    frame(16'h5678, 16'h0000);
    frame(16'h9ABC, 16'h0000);
    chk("t3_ovr", ovr, 1'b1);
    chk("t3_req_held", req, 1'b1);
    chk("t3_wdata_held", wdata, 16'h1234);
    chk("t3_addr_held", addr, 20'd1);
    chk("t3_len_held", rec_len, 20'd1);
    auto_ack = 1'b1;
    tick(3);
    chk("t3_len_acked", rec_len, 20'd2);
    chk("t3_req_clr", req, 1'b0);
    exp_q.push_back('{addr: 20'd2, data: 16'h0F0F});
    frame(16'h0F0F, 16'h0000);
    chk("t3_len", rec_len, 20'd3);

    // Pause mid-word, ignore a frame, resume and re-align
    frame(16'hDEAD, 16'h0000, 8);
    pulse(1'b1, 1'b0, 1'b0);
    chk("t4_pause", state, 2'd3);
    frame(16'hBEEF, 16'h0000);
    chk("t4_len_paused", rec_len, 20'd3);
    pulse(1'b1, 1'b0, 1'b0);
    chk("t4_rearm", state, 2'd1);
    exp_q.push_back('{addr: 20'd3, data: 16'h1357});
    frame(16'h1357, 16'h0000);
    chk("t4_state", state, 2'd2);
    chk("t4_len", rec_len, 20'd4);
    chk("t4_ovr_sticky", ovr, 1'b1);

    // Malformed frame: LRCK falls again mid-word, partial is dropped
    frame(16'hFFFF, 16'h0000, 8);
    slot(1'b1, 1'b0);
    exp_q.push_back('{addr: 20'd4, data: 16'h2468});
    frame(16'h2468, 16'h0000);
    chk("mid_len", rec_len, 20'd5);
    chk("mid_drained", exp_q.size(), 0);

    // stop wins over recordorpause; record switch low aborts ARM
    pulse(1'b1, 1'b1, 1'b0);
    chk("t6_stop_wins", state, 2'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("t6_arm", state, 2'd1);
    chk("t6_new_take_len", rec_len, 20'd0);
    chk("t6_new_take_ovr", ovr, 1'b0);
    @(negedge clk);
    record = 1'b0;
    tick(1);
    chk("t6_record_low", state, 2'd0);
    record = 1'b1;

    // Asynchronous reset while a write is pending
    pulse(1'b1, 1'b0, 1'b0);
    auto_ack = 1'b0;
    exp_q.push_back('{addr: 20'd0, data: 16'hCAFE});
    frame(16'hCAFE, 16'h0000);
    chk("t1_req_pending", req, 1'b1);
    chk("t1_state", state, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_req", req, 1'b0);
    chk("t1_rst_state", state, 2'd0);
    chk("t1_rst_wdata", wdata, 16'h0000);
    chk("t1_rst_addr", addr, 20'd0);
    tick(2);
    rst_n  = 1'b1;
    record = 1'b0;
    tick(2);

    // Small instance: 8 samples fill memory, 4 samples per second
    record_s = 1'b1;
    pulse(1'b0, 1'b0, 1'b1);
    chk("t5_arm", state_s, 2'd1);
    auto_ack_s = 1'b1;
    for (int k = 0; k < 8; k++) frame(16'h1111 * 16'(k + 1), 16'h0000);
    tick(4);
    chk("t5_writes", wr_cnt_s, 8);
    chk("t5_full_pulses", full_cnt_s, 1);
    chk("t5_state", state_s, 2'd0);
    chk("t5_sec", sec_s, 8'd2);
    chk("t5_len", rec_len_s, 20'd8);
    chk("t5_ovr", ovr_s, 1'b0);
    chk("main_never_full", full_cnt, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
